regfile_mp: RTL and testbench

Parametrised multi-ported integer register file for the RISC-V pipeline, replacing the fixed 32x32, 2-read/1-write file. It provides NREAD registered read ports, NWRITE prioritised write ports, a per-register busy scoreboard for pending writebacks, and a registered debug read port. It sits between decode (reads, claims) and writeback (writes).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_wr_arbiter.sv | 24 ++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and word typedef for the multi-ported register file.
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [XLEN_DEF-1:0] word_t;
endpackage

// File: rtl/regfile_wr_arbiter.sv
// Combinational winner select for one address across all write ports; highest index wins.
module regfile_wr_arbiter #(
  parameter int AW     = 5,
  parameter int NWRITE = 2,
  parameter int SW     = 1
) (
  input  logic [NWRITE-1:0]    wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic [AW-1:0]        addr,
  output logic                 hit,
  output logic [SW-1:0]        sel
);
  always_comb begin
    hit = 1'b0;
    sel = '0;
    // Ascending scan so a later (higher-priority) port overrides earlier matches.
    for (int i = 0; i < NWRITE; i++) begin
      if (wr_en[i] && wr_addr[i*AW +: AW] == addr) begin
        hit = 1'b1;
        sel = SW'(i);
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with busy scoreboard and debug port.
// Define REGFILE_BYPASS_EN to forward same-edge writes to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   claim_en,
  input  logic [AW-1:0]          claim_addr,
  input  logic [AW-1:0]          dbg_addr,
  output logic [XLEN-1:0]        dbg_data
);
  localparam int SW = (NWRITE > 1) ? $clog2(NWRITE) : 1;

  logic [NWRITE-1:0][XLEN-1:0] wr_word;
  logic [DEPTH-1:0][XLEN-1:0]  mem;
  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0]            arb_hit, wr_hit, claim_hit;
  logic [DEPTH-1:0][SW-1:0]    arb_sel;
  logic [NREAD-1:0][XLEN-1:0]  rd_nxt;
  logic [NREAD-1:0]            rd_nxt_busy;

  assign wr_word = wr_data;

  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    localparam bit IS_ZERO = (ZERO_REG != 0) && (r == 0);
    regfile_wr_arbiter #(.AW(AW), .NWRITE(NWRITE), .SW(SW)) u_arb (
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .addr   (AW'(r)),
      .hit    (arb_hit[r]),
      .sel    (arb_sel[r])
    );
    assign wr_hit[r]    = arb_hit[r] && !IS_ZERO;
    assign claim_hit[r] = claim_en && (claim_addr == AW'(r)) && !IS_ZERO;
  end

  // A claim outranks a same-edge write: a newer producer is still outstanding.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit[r]) mem[r] <= wr_word[arb_sel[r]];
        if (claim_hit[r])    busy[r] <= 1'b1;
        else if (wr_hit[r])  busy[r] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign rd_nxt[k]      = wr_hit[a] ? wr_word[arb_sel[a]] : mem[a];
    assign rd_nxt_busy[k] = wr_hit[a] ? claim_hit[a] : busy[a];
`else
    assign rd_nxt[k]      = mem[a];
    assign rd_nxt_busy[k] = busy[a];
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_busy  <= '0;
      dbg_data <= '0;
    end else begin
      rd_data  <= rd_nxt;
      rd_busy  <= rd_nxt_busy;
      dbg_data <= mem[dbg_addr];
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: random and directed traffic against a sequential reference model.
module tb_regfile_mp;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock, reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr, dbg_addr;
  logic [31:0] dbg_data;

  regfile_mp dut (
    .clock(clock), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0][31:0] data;
    logic [1:0]       busy;
    logic [31:0]      dbg;
  } exp_t;

  exp_t  sb[$];
  word_t m_reg[32];
  bit    m_busy[32];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply writes in port order, then derive what each port sees.
  word_t      old_reg[32];
  bit         old_busy[32];
  bit [31:0]  written;
  logic [4:0] ma;
  exp_t       me;
  always @(posedge clock) begin
    if (!reset) begin
      old_reg  = m_reg;
      old_busy = m_busy;
      written  = '0;
      for (int p = 0; p < 2; p++) begin
        ma = wr_addr[p*5 +: 5];
        if (wr_en[p] && ma != 5'd0) begin
          m_reg[ma]   = wr_data[p*32 +: 32];
          written[ma] = 1'b1;
        end
      end
      for (int i = 0; i < 32; i++) if (written[i]) m_busy[i] = 1'b0;
      if (claim_en && claim_addr != 5'd0) m_busy[claim_addr] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        ma = rd_addr[k*5 +: 5];
        me.data[k] = (BYP && written[ma]) ? m_reg[ma]  : old_reg[ma];
        me.busy[k] = (BYP && written[ma]) ? m_busy[ma] : old_busy[ma];
      end
      me.dbg = old_reg[dbg_addr];
      sb.push_back(me);
    end
  end

  exp_t mon_e;
  always @(negedge clock) begin
    if (!reset && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("sb_rd0", 64'(rd_data[31:0]),  64'(mon_e.data[0]));
      chk("sb_rd1", 64'(rd_data[63:32]), 64'(mon_e.data[1]));
      chk("sb_busy", 64'(rd_busy), 64'(mon_e.busy));
      chk("sb_dbg", 64'(dbg_data), 64'(mon_e.dbg));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic idle();
    wr_en    = '0;
    claim_en = 1'b0;
  endtask
  task automatic wr(input int p, input int a, input logic [31:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*5 +: 5]   = 5'(a);
    wr_data[p*32 +: 32] = d;
  endtask
  task automatic rd(input int k, input int a);
    rd_addr[k*5 +: 5] = 5'(a);
  endtask
  task automatic claim(input int a);
    claim_en   = 1'b1;
    claim_addr = 5'(a);
  endtask
  task automatic model_clear();
    sb.delete();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; dbg_addr = '0;
    model_clear();
    #1;
    chk("por_rd", rd_data, 64'd0);
    chk("por_busy", 64'(rd_busy), 64'd0);
    #11 reset = 1'b0;
    tick();

    // Preload, then async reset mid-cycle
    idle(); wr(0, 5, 32'hDEADBEEF); claim(7); tick();
    idle(); rd(0, 7); rd(1, 5); dbg_addr = 5'd5; tick();
    chk("pre_busy7", 64'(rd_busy[0]), 64'd1);
    chk("pre_x5", 64'(rd_data[63:32]), 64'hDEADBEEF);
    reset = 1'b1;
    model_clear();
    #1;
    chk("rst_rd", rd_data, 64'd0);
    chk("rst_dbg", 64'(dbg_data), 64'd0);
    chk("rst_busy", 64'(rd_busy), 64'd0);
    #4 reset = 1'b0;
    tick();
    chk("post_rst_x5", 64'(rd_data[63:32]), 64'd0);
    chk("post_rst_busy7", 64'(rd_busy[0]), 64'd0);

    // Zero register
    idle(); wr(0, 0, 32'h12345678); wr(1, 0, 32'h12345678); claim(0); rd(0, 0); tick();
    idle(); tick();
    chk("x0_data", 64'(rd_data[31:0]), 64'd0);
    chk("x0_busy", 64'(rd_busy[0]), 64'd0);

    // Write priority
    idle(); wr(0, 3, 32'h11); wr(1, 3, 32'h22); tick();
    idle(); rd(0, 3); tick();
    chk("prio_x3", 64'(rd_data[31:0]), 64'h22);

    // Scoreboard
    idle(); claim(9); tick();
    idle(); rd(0, 9); tick();
    chk("sb_claim9", 64'(rd_busy[0]), 64'd1);
    idle(); wr(0, 9, 32'hA5); claim(9); tick();
    idle(); tick();
    chk("sb_wr_claim9", 64'(rd_busy[0]), 64'd1);
    chk("x9_a5", 64'(rd_data[31:0]), 64'hA5);
    idle(); wr(1, 9, 32'h5A); tick();
    idle(); tick();
    chk("sb_clear9", 64'(rd_busy[0]), 64'd0);
    chk("x9_5a", 64'(rd_data[31:0]), 64'h5A);

    // Same-edge read/write
    idle(); wr(0, 4, 32'h1); rd(0, 0); tick();
    idle(); wr(1, 4, 32'h2); rd(0, 4); tick();
    chk("bypass_x4", 64'(rd_data[31:0]), BYP ? 64'h2 : 64'h1);
    idle(); tick();
    chk("after_x4", 64'(rd_data[31:0]), 64'h2);

    // Debug port
    idle(); wr(0, 31, 32'hCAFEF00D); rd(0, 9); tick();
    idle(); dbg_addr = 5'd31; tick();
    chk("dbg_x31", 64'(dbg_data), 64'hCAFEF00D);
    chk("dbg_busy", 64'(rd_busy[0]), 64'd0);

    // Random traffic on a narrow address window to force collisions
    for (int n = 0; n < 400; n++) begin
      wr_en      = 2'($urandom_range(0, 3));
      wr_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data    = {$urandom, $urandom};
      claim_en   = 1'($urandom_range(0, 1));
      claim_addr = 5'($urandom_range(0, 7));
      rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      dbg_addr   = 5'($urandom_range(0, 7));
      tick();
    end
    idle(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
